rxfifo_param: RTL and testbench

RXFIFO_PARAM -- requirements
Module: rxfifo_param

---
 rtl/rxfifo_pkg.sv | 33 +++
 rtl/rxfifo_timeout.sv | 48 ++++
 rtl/rxfifo_param.sv | 130 +++++++++++++
 tb/tb_rxfifo_param.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/rxfifo_pkg.sv
// rtl/rxfifo_pkg.sv - shared constants and helpers for the receive FIFO
//
// Holds the default configuration of rxfifo_param, a constant-foldable
// ceiling-log2 helper, and the width of the rx_level count.

package rxfifo_pkg;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_DEPTH       = 4;
    localparam int DEF_RX_THRESH   = 2;
    localparam int DEF_TIMEOUT_CYC = 32;

    // Idle counter width; covers the full 2..65535 timeout range.
    localparam int TMO_CNT_W = 16;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    // rx_level must represent 0..DEPTH inclusive, hence the extra bit.
    function automatic int level_w(input int depth);
        return clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rxfifo_timeout.sv
// rtl/rxfifo_timeout.sv - idle counter raising the receive-timeout interrupt
//
// Ports:
//   clk_i      clock, rising edge
//   rst_i      asynchronous active-high reset
//   nonempty_i FIFO holds at least one entry
//   activity_i a push or pop completes this cycle
//   tmo_o      counter has reached TIMEOUT_CYC
// The counter saturates at TIMEOUT_CYC so tmo_o holds until activity,
// emptiness or reset returns it to zero.

module rxfifo_timeout
    import rxfifo_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic nonempty_i,
    input  logic activity_i,
    output logic tmo_o
);

    localparam logic [TMO_CNT_W-1:0] LIMIT = TMO_CNT_W'(TIMEOUT_CYC);

    logic [TMO_CNT_W-1:0] cnt_q;
    logic [TMO_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (activity_i || !nonempty_i) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + TMO_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tmo_o = (cnt_q == LIMIT);

endmodule

// File: rtl/rxfifo_param.sv
// rtl/rxfifo_param.sv - parameterised receive FIFO with level, overrun and timeout interrupts
//
// Ports:
//   PCLK        sole clock, rising edge
//   CLEAR       asynchronous active-high reset
//   PSEL/PWRITE bus select/direction; PSEL & ~PWRITE requests a pop
//   RxData      receive data, captured when rx_ready is high
//   rx_ready    single-cycle push strobe
//   ror_clr     clears the sticky overrun flag
//   PRDATA      registered popped data
//   SSPRXINTR   rx_level >= RX_THRESH
//   SSPRORINTR  sticky overrun
//   SSPRTINTR   receive timeout (only when RXFIFO_TIMEOUT_EN is defined, else 0)
//   rx_empty, rx_full, rx_level  occupancy status
// Build option: define RXFIFO_TIMEOUT_EN to include the idle-timeout counter.

module rxfifo_param
    import rxfifo_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int RX_THRESH   = DEF_RX_THRESH,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                      PCLK,
    input  logic                      CLEAR,
    input  logic                      PSEL,
    input  logic                      PWRITE,
    input  logic [DATA_W-1:0]         RxData,
    input  logic                      rx_ready,
    input  logic                      ror_clr,
    output logic [DATA_W-1:0]         PRDATA,
    output logic                      SSPRXINTR,
    output logic                      SSPRORINTR,
    output logic                      SSPRTINTR,
    output logic                      rx_empty,
    output logic                      rx_full,
    output logic [level_w(DEPTH)-1:0] rx_level
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int LVL_W = level_w(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [DATA_W-1:0] prdata_q, prdata_d;
    logic              ror_q, ror_d;

    logic empty, full, pop, push, overrun;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LVL_W'(DEPTH));
    assign pop     = PSEL && !PWRITE && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push    = rx_ready && (!full || pop);
    assign overrun = rx_ready && full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        prdata_d = prdata_q;
        ror_d    = ror_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            prdata_d = mem_q[rd_ptr_q];
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        // Set has priority over clear.
        if (overrun) begin
            ror_d = 1'b1;
        end else if (ror_clr) begin
            ror_d = 1'b0;
        end
    end

    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            prdata_q <= '0;
            ror_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            prdata_q <= prdata_d;
            ror_q    <= ror_d;
        end
    end

    // Storage is not reset; stale contents are unreachable once level is 0.
    always_ff @(posedge PCLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= RxData;
        end
    end

`ifdef RXFIFO_TIMEOUT_EN
    rxfifo_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk_i      (PCLK),
        .rst_i      (CLEAR),
        .nonempty_i (!empty),
        .activity_i (push || pop),
        .tmo_o      (SSPRTINTR)
    );
`else
    assign SSPRTINTR = 1'b0;
`endif

    assign PRDATA     = prdata_q;
    assign SSPRXINTR  = (level_q >= LVL_W'(RX_THRESH));
    assign SSPRORINTR = ror_q;
    assign rx_empty   = empty;
    assign rx_full    = full;
    assign rx_level   = level_q;

endmodule

// File: tb/tb_rxfifo_param.sv
// tb/tb_rxfifo_param.sv - directed table-driven bench for rxfifo_param

module tb_rxfifo_param;

    logic       PCLK;
    logic       CLEAR;
    logic       PSEL;
    logic       PWRITE;
    logic [7:0] RxData;
    logic       rx_ready;
    logic       ror_clr;
    logic [7:0] PRDATA;
    logic       SSPRXINTR;
    logic       SSPRORINTR;
    logic       SSPRTINTR;
    logic       rx_empty;
    logic       rx_full;
    logic [2:0] rx_level;

    int errors = 0;
    int checks = 0;

    rxfifo_param #(
        .DATA_W      (8),
        .DEPTH       (4),
        .RX_THRESH   (2),
        .TIMEOUT_CYC (32)
    ) dut (
        .PCLK       (PCLK),
        .CLEAR      (CLEAR),
        .PSEL       (PSEL),
        .PWRITE     (PWRITE),
        .RxData     (RxData),
        .rx_ready   (rx_ready),
        .ror_clr    (ror_clr),
        .PRDATA     (PRDATA),
        .SSPRXINTR  (SSPRXINTR),
        .SSPRORINTR (SSPRORINTR),
        .SSPRTINTR  (SSPRTINTR),
        .rx_empty   (rx_empty),
        .rx_full    (rx_full),
        .rx_level   (rx_level)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        logic       psel;
        logic       pwrite;
        logic       rdy;
        logic       clr;
        logic [7:0] d;
        logic [2:0] lvl;
        logic [7:0] pd;
        logic       emp;
        logic       full;
        logic       rxi;
        logic       ror;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic psel, input logic pwrite, input logic rdy,
                                input logic clr, input logic [7:0] d, input logic [2:0] lvl,
                                input logic [7:0] pd, input logic emp, input logic full,
                                input logic rxi, input logic ror);
        vec_t v;
        v.psel = psel; v.pwrite = pwrite; v.rdy = rdy; v.clr = clr; v.d = d;
        v.lvl = lvl; v.pd = pd; v.emp = emp; v.full = full; v.rxi = rxi; v.ror = ror;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic psel, input logic pwrite, input logic rdy,
                         input logic clr, input logic [7:0] d);
        PSEL = psel; PWRITE = pwrite; rx_ready = rdy; ror_clr = clr; RxData = d;
    endtask

    task automatic cycle();
        @(posedge PCLK);
        #1;
    endtask

    initial begin
        CLEAR = 1'b1;
        drive(0, 0, 0, 0, 8'h00);
        #3;
        chk("rst_level", 32'(rx_level), 0);
        chk("rst_empty", 32'(rx_empty), 1);
        chk("rst_full", 32'(rx_full), 0);
        chk("rst_rxintr", 32'(SSPRXINTR), 0);
        chk("rst_ror", 32'(SSPRORINTR), 0);
        chk("rst_rt", 32'(SSPRTINTR), 0);
        chk("rst_prdata", 32'(PRDATA), 0);
        #9 CLEAR = 1'b0;
        cycle();

        //        psel pw rdy clr d      lvl pd     emp full rxi ror
        vecs.push_back(mk(0, 0, 1, 0, 8'h11, 1, 8'h00, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 8'h22, 2, 8'h00, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 1, 8'h11, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 0, 8'h22, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 0, 8'h22, 1, 0, 0, 0)); // pop on empty
        vecs.push_back(mk(1, 1, 1, 0, 8'h77, 1, 8'h22, 0, 0, 0, 0)); // write access is not a pop
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 0, 8'h77, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 8'h99, 1, 8'h77, 0, 0, 0, 0)); // push+pop on empty
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 0, 8'h99, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 8'hA0, 1, 8'h99, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 8'hA1, 2, 8'h99, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 8'hA2, 3, 8'h99, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 8'hA3, 4, 8'h99, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 8'hA4, 4, 8'h99, 0, 1, 1, 1)); // overrun
        vecs.push_back(mk(0, 0, 0, 1, 8'h00, 4, 8'h99, 0, 1, 1, 0)); // ror_clr
        vecs.push_back(mk(1, 0, 1, 0, 8'h55, 4, 8'hA0, 0, 1, 1, 0)); // full push+pop
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 3, 8'hA1, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 2, 8'hA2, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 1, 8'hA3, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 0, 8'h55, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 8'hB0, 1, 8'h55, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 8'hB1, 2, 8'h55, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 8'hB2, 3, 8'h55, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 8'hB3, 4, 8'h55, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 8'hB4, 4, 8'h55, 0, 1, 1, 1)); // set beats clear
        vecs.push_back(mk(0, 0, 0, 1, 8'h00, 4, 8'h55, 0, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 3, 8'hB0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 2, 8'hB1, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 1, 8'hB2, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 0, 8'hB3, 1, 0, 0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].psel, vecs[i].pwrite, vecs[i].rdy, vecs[i].clr, vecs[i].d);
            cycle();
            chk($sformatf("v%0d_level", i), 32'(rx_level), 32'(vecs[i].lvl));
            chk($sformatf("v%0d_prdata", i), 32'(PRDATA), 32'(vecs[i].pd));
            chk($sformatf("v%0d_empty", i), 32'(rx_empty), 32'(vecs[i].emp));
            chk($sformatf("v%0d_full", i), 32'(rx_full), 32'(vecs[i].full));
            chk($sformatf("v%0d_rxintr", i), 32'(SSPRXINTR), 32'(vecs[i].rxi));
            chk($sformatf("v%0d_ror", i), 32'(SSPRORINTR), 32'(vecs[i].ror));
            chk($sformatf("v%0d_rt", i), 32'(SSPRTINTR), 0);
        end

        // Ten simultaneous push/pop pairs around a one-entry FIFO: pointers wrap.
        drive(0, 0, 1, 0, 8'h30);
        cycle();
        for (int i = 1; i <= 10; i++) begin
            drive(1, 0, 1, 0, 8'(8'h30 + i));
            cycle();
            chk($sformatf("wrap%0d_prdata", i), 32'(PRDATA), 32'(8'h30 + i - 1));
            chk($sformatf("wrap%0d_level", i), 32'(rx_level), 1);
        end
        drive(1, 0, 0, 0, 8'h00);
        cycle();
        chk("wrap_last", 32'(PRDATA), 32'h3A);
        chk("wrap_empty", 32'(rx_empty), 1);

        // Receive timeout with one idle entry.
        drive(0, 0, 1, 0, 8'h44);
        cycle();
        drive(0, 0, 0, 0, 8'h00);
`ifdef RXFIFO_TIMEOUT_EN
        repeat (31) cycle();
        chk("tmo_31", 32'(SSPRTINTR), 0);
        cycle();
        chk("tmo_32", 32'(SSPRTINTR), 1);
        cycle();
        chk("tmo_hold", 32'(SSPRTINTR), 1);
`else
        repeat (40) cycle();
        chk("tmo_off", 32'(SSPRTINTR), 0);
`endif
        drive(1, 0, 0, 0, 8'h00);
        cycle();
        chk("tmo_pop_clr", 32'(SSPRTINTR), 0);
        chk("tmo_pop_data", 32'(PRDATA), 32'h44);

        // Asynchronous reset with three entries stored.
        drive(0, 0, 1, 0, 8'hC0); cycle();
        drive(0, 0, 1, 0, 8'hC1); cycle();
        drive(0, 0, 1, 0, 8'hC2); cycle();
        drive(1, 0, 1, 0, 8'hC3); cycle();
        drive(0, 0, 0, 0, 8'h00);
        chk("pre_clr_level", 32'(rx_level), 3);
        chk("pre_clr_prdata", 32'(PRDATA), 32'hC0);
        #2 CLEAR = 1'b1;
        #1;
        chk("clr_level", 32'(rx_level), 0);
        chk("clr_empty", 32'(rx_empty), 1);
        chk("clr_full", 32'(rx_full), 0);
        chk("clr_rxintr", 32'(SSPRXINTR), 0);
        chk("clr_prdata", 32'(PRDATA), 0);
        @(posedge PCLK);
        #2 CLEAR = 1'b0;
        @(negedge PCLK);
        drive(1, 0, 0, 0, 8'h00);
        cycle();
        chk("post_clr_prdata", 32'(PRDATA), 0);
        chk("post_clr_level", 32'(rx_level), 0);
        drive(0, 0, 0, 0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
